id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 32-bit MIPS pipeline; consumes the 32-bit sign-extended immediate produced by the sign-extension unit in ID.
- Selects the final immediate form, detects load-use hazards, and registers all operands and control for EX.
- Converts hazards and flushes into pipeline bubbles.

Parameters:
- DATA_W, 32, datapath / operand width
- REG_ADDR_W, 5, register-file address width
- ALU_OP_W, 4, ALU operation code width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- id_valid  input  1  ID holds a real instruction
- id_instr  input  32  raw instruction in ID
- id_pc4  input  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  input  DATA_W  register-file read data
- id_imm_sext  input  DATA_W  sign-extended immediate from the sign-extension unit
- id_imm_sel  input  2  00 sext, 01 zext, 10 lui, 11 shamt
- id_uses_rt  input  1  instruction reads rt as a source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_branch  input  1 each  decoded control
- id_alu_op  input  ALU_OP_W  ALU operation
- flush  input  1  branch/jump redirect from EX; kill the ID instruction
- stall_out  output  1  load-use stall; hold PC and IF/ID
- ex_valid  output  1  EX holds a real instruction
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  output  DATA_W  registered operands
- ex_rs, ex_rt, ex_dest  output  REG_ADDR_W  source and destination register numbers
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  output  1 each  registered control
- ex_alu_op  output  ALU_OP_W  registered ALU operation

Behaviour:
- Reset (rst=1 at posedge): every ex_* output cleared to 0, including ex_valid. stall_out is combinational and is 0 while ex_valid=0.
- Imm select (combinational):
  - 00: id_imm_sext
  - 01: {16'b0, instr[15:0]}
  - 10: {instr[15:0], 16'b0}
  - 11: {27'b0, instr[10:6]}
- Destination: ex_dest = id_reg_dst ? instr[15:11] : instr[20:16], captured at the register.
- Hazard (combinational): stall_out = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == instr[25:21]) | (id_uses_rt & ex_rt == instr[20:16])) & ~flush.
- Register update, per cycle, in priority order:
  - rst: clear all.
  - flush: insert bubble. ex_valid=0; all control outputs (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op) = 0. Data fields: don't-care; hold previous values.
  - stall_out: insert bubble, identical to flush. ID contents are held upstream and re-presented next cycle.
  - Otherwise capture all ID fields. ex_valid=id_valid. If id_valid=0, force all control outputs to 0.
- Latency: one cycle from ID to EX. A stall lasts exactly one cycle per load-use pair: after the bubble, ex_mem_read=0, so the hazard clears.
- Register $0: a load to $0 never stalls.
- Simultaneous flush and hazard: flush wins; stall_out=0 so the PC redirect is not blocked.
- Reset mid-stall: stall_out drops the same cycle the clearing edge takes effect.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt, 32 bits each.
  - Each increments on every clock edge where its bubble is inserted; a flush does not also count as a stall.
  - Both cleared by rst; both wrap at 2^32-1 -> 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (mips_pkg):
  - IMM_SEXT/IMM_ZEXT/IMM_LUI/IMM_SHAMT encodings
  - ALU_OP_W
  - instruction field bit positions (RS_MSB/LSB, RT, RD, SHAMT)
- Sub-module: load_use_detect, holding the purely combinational stall equation. The register and immediate mux stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary ID inputs -> all ex_* = 0, stall_out = 0.
- Immediate forms: instr[15:0]=16'h8001, id_imm_sext=32'hFFFF8001:
  - sel 00 -> ex_imm=32'hFFFF8001
  - sel 01 -> 32'h00008001
  - sel 10 -> 32'h80010000
  - sel 11 with instr[10:6]=5'd3 -> 32'h3
- Load-use: lw $8 in EX, then add $9,$8,$1 in ID -> stall_out=1 for one cycle; next edge ex_valid=0 with controls 0; following edge add captured, stall_out=0.
- Register $0 and rt-not-used: lw $0 then use of $0 -> no stall. lw $8 then addi with rt=$8 and id_uses_rt=0 -> no stall.
- Flush vs hazard: same setup as load-use plus flush=1 -> stall_out=0, bubble inserted; with IDEX_PERF_CNT_EN, perf_flush_cnt=1 and perf_stall_cnt=0.
- Counter wrap (IDEX_PERF_CNT_EN): force perf_stall_cnt=32'hFFFFFFFF, trigger one stall -> counter reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: immediate-form encodings, ALU op width and
// instruction field bit positions.
package mips_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'b00,
    IMM_ZEXT  = 2'b01,
    IMM_LUI   = 2'b10,
    IMM_SHAMT = 2'b11
  } imm_sel_e;

  localparam int ALU_OP_W  = 4;
  localparam int INSTR_W   = 32;

  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load in EX is about to write. Purely combinational.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  id_uses_rt,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  stall
);
  import mips_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  reads_load_dest;
  logic                  unused_fields;

  assign id_rs = id_instr[RS_MSB:RS_LSB];
  assign id_rt = id_instr[RT_MSB:RT_LSB];
  assign unused_fields = ^{id_instr[31:26], id_instr[15:0]};

  assign reads_load_dest = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));

  // A load to $0 never produces a value worth waiting for; a redirect must never be blocked
  assign stall = id_valid & ex_valid & ex_mem_read & (ex_rt != '0)
               & reads_load_dest & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: immediate select, load-use stall and bubble insertion.
// Optional IDEX_PERF_CNT_EN adds stall/flush bubble counters.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = mips_pkg::ALU_OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm_sext,
  input  logic [1:0]            id_imm_sel,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [ALU_OP_W-1:0]   ex_alu_op
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);
  import mips_pkg::*;

  imm_sel_e          imm_kind;
  logic [DATA_W-1:0] imm_final;
  logic              bubble;
  logic              unused_opcode;

  assign imm_kind      = imm_sel_e'(id_imm_sel);
  assign unused_opcode = ^id_instr[31:26];

  always_comb begin
    imm_final = id_imm_sext;
    unique case (imm_kind)
      IMM_SEXT:  imm_final = id_imm_sext;
      IMM_ZEXT:  imm_final = {{(DATA_W-16){1'b0}}, id_instr[IMM_MSB:IMM_LSB]};
      IMM_LUI:   imm_final = {id_instr[IMM_MSB:IMM_LSB], {(DATA_W-16){1'b0}}};
      IMM_SHAMT: imm_final = {{(DATA_W-5){1'b0}}, id_instr[SHAMT_MSB:SHAMT_LSB]};
      default:   imm_final = id_imm_sext;
    endcase
  end

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_uses_rt  (id_uses_rt),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .stall       (stall_out)
  );

  assign bubble = flush | stall_out;

  // Bubbles only kill control; data fields keep their last values since EX ignores them
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
    end else begin
      ex_valid      <= id_valid;
      ex_pc4        <= id_pc4;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= imm_final;
      ex_rs         <= id_instr[RS_MSB:RS_LSB];
      ex_rt         <= id_instr[RT_MSB:RT_LSB];
      ex_dest       <= id_reg_dst ? id_instr[RD_MSB:RD_LSB] : id_instr[RT_MSB:RT_LSB];
      ex_reg_write  <= id_valid & id_reg_write;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      ex_alu_src    <= id_valid & id_alu_src;
      ex_branch     <= id_valid & id_branch;
      ex_alu_op     <= id_valid ? id_alu_op : '0;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // stall_out is already suppressed by flush, so each bubble lands in exactly one counter
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (flush) begin
      perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end else if (stall_out) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
